dmem_arbiter: RTL and testbench

- Shares the single-port data RAM (12-bit word address, 32-bit data, synchronous read) between two requesters: port 0 (processor load/store path) and port 1 (debug/host loader or DMA).
- Sits between the requesters and the RAM instance and drives the RAM's write enable, address and write data.
- Grants at most one access per cycle and returns read data one cycle after grant, tagged to the requester that issued the read.
- Keeps a saturating conflict counter for performance debug.

---
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read data RAM.
// One access per cycle, read data returned the next cycle tagged to its requester.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RR_ENABLE  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_wen,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_wen,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  mem_wEn,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_dataIn,
    input  logic [DATA_WIDTH-1:0] mem_dataOut,
    output logic [CNT_WIDTH-1:0]  conflict_count
);

    logic                 last_grant_q, last_grant_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 rd_tag_q, rd_tag_d;
    logic [CNT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;
    logic                 grant0, grant1, both_valid;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    // Grant selection; reset gates every grant so nothing reaches the RAM.
    always_comb begin
        both_valid = req0_valid && req1_valid;
        grant0     = 1'b0;
        grant1     = 1'b0;
        if (!reset) begin
            if (both_valid) begin
                if ((RR_ENABLE != 0) && (last_grant_q == 1'b0)) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_comb begin
        mem_wEn        = 1'b0;
        mem_addr       = '0;
        mem_dataIn     = '0;
        last_grant_d   = last_grant_q;
        rd_pend_d      = 1'b0;
        rd_tag_d       = rd_tag_q;
        conflict_cnt_d = both_valid ? sat_inc(conflict_cnt_q) : conflict_cnt_q;
        if (grant0) begin
            mem_wEn      = req0_wen;
            mem_addr     = req0_addr;
            mem_dataIn   = req0_wdata;
            last_grant_d = 1'b0;
            rd_pend_d    = !req0_wen;
            rd_tag_d     = req0_wen ? rd_tag_q : 1'b0;
        end else if (grant1) begin
            mem_wEn      = req1_wen;
            mem_addr     = req1_addr;
            mem_dataIn   = req1_wdata;
            last_grant_d = 1'b1;
            rd_pend_d    = !req1_wen;
            rd_tag_d     = req1_wen ? rd_tag_q : 1'b1;
        end
    end

    // Control state; last_grant resets to 1 so port 0 wins the first conflict.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q   <= 1'b1;
            rd_pend_q      <= 1'b0;
            rd_tag_q       <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            rd_pend_q      <= rd_pend_d;
            rd_tag_q       <= rd_tag_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Read return stage: a read pending across a reset edge is never reported.
    always_comb begin
        req0_ready  = grant0;
        req1_ready  = grant1;
        req0_rvalid = rd_pend_q && !rd_tag_q && !reset;
        req1_rvalid = rd_pend_q && rd_tag_q && !reset;
        req0_rdata  = req0_rvalid ? mem_dataOut : '0;
        req1_rdata  = req1_rvalid ? mem_dataOut : '0;
    end

    assign conflict_count = conflict_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance backed by a small RAM
// model, and a fixed-priority instance with a 4-bit conflict counter.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Instance A: RR_ENABLE=1, default widths
    logic        a_reset = 1'b0;
    logic        a_v0 = 1'b0, a_w0 = 1'b0, a_v1 = 1'b0, a_w1 = 1'b0;
    logic [11:0] a_ad0 = '0, a_ad1 = '0;
    logic [31:0] a_wd0 = '0, a_wd1 = '0;
    logic        a_rdy0, a_rdy1, a_rv0, a_rv1, a_mwen;
    logic [31:0] a_rd0, a_rd1, a_mdin, a_mdout;
    logic [11:0] a_maddr;
    logic [15:0] a_cc;

    logic [31:0] ram [0:4095];
    always @(posedge clk) begin
        if (a_mwen) ram[a_maddr] <= a_mdin;
        a_mdout <= ram[a_maddr];
    end

    dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RR_ENABLE(1), .CNT_WIDTH(16)) dut_a (
        .clock(clk), .reset(a_reset),
        .req0_valid(a_v0), .req0_wen(a_w0), .req0_addr(a_ad0), .req0_wdata(a_wd0),
        .req0_ready(a_rdy0), .req0_rvalid(a_rv0), .req0_rdata(a_rd0),
        .req1_valid(a_v1), .req1_wen(a_w1), .req1_addr(a_ad1), .req1_wdata(a_wd1),
        .req1_ready(a_rdy1), .req1_rvalid(a_rv1), .req1_rdata(a_rd1),
        .mem_wEn(a_mwen), .mem_addr(a_maddr), .mem_dataIn(a_mdin), .mem_dataOut(a_mdout),
        .conflict_count(a_cc)
    );

    // Instance B: fixed priority, 4-bit counter
    logic        b_reset = 1'b0;
    logic        b_v0 = 1'b0, b_v1 = 1'b0;
    logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_mwen;
    logic [31:0] b_rd0, b_rd1, b_mdin;
    logic [31:0] b_mdout = '0;
    logic [11:0] b_maddr;
    logic [3:0]  b_cc;

    dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RR_ENABLE(0), .CNT_WIDTH(4)) dut_b (
        .clock(clk), .reset(b_reset),
        .req0_valid(b_v0), .req0_wen(1'b0), .req0_addr(12'h005), .req0_wdata(32'h0),
        .req0_ready(b_rdy0), .req0_rvalid(b_rv0), .req0_rdata(b_rd0),
        .req1_valid(b_v1), .req1_wen(1'b0), .req1_addr(12'h006), .req1_wdata(32'h0),
        .req1_ready(b_rdy1), .req1_rvalid(b_rv1), .req1_rdata(b_rd1),
        .mem_wEn(b_mwen), .mem_addr(b_maddr), .mem_dataIn(b_mdin), .mem_dataOut(b_mdout),
        .conflict_count(b_cc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        ram[1] = 32'h11;
        ram[2] = 32'h22;

        // Reset cycle with both ports requesting: everything gated
        next_cycle();
        a_reset = 1'b1; a_v0 = 1'b1; a_w0 = 1'b1; a_v1 = 1'b1; a_w1 = 1'b1;
        #1;
        check("rst_ready0", a_rdy0, 0);
        check("rst_ready1", a_rdy1, 0);
        check("rst_mem_wen", a_mwen, 0);

        // Write 0x010 then read it back on port 0
        next_cycle();
        a_reset = 1'b0; a_v1 = 1'b0; a_w1 = 1'b0;
        a_v0 = 1'b1; a_w0 = 1'b1; a_ad0 = 12'h010; a_wd0 = 32'hDEADBEEF;
        #1;
        check("post_rst_rvalid0", a_rv0, 0);
        check("post_rst_rvalid1", a_rv1, 0);
        check("post_rst_cc", a_cc, 0);
        check("wr_ready0", a_rdy0, 1);
        check("wr_mem_wen", a_mwen, 1);
        check("wr_mem_addr", a_maddr, 32'h010);
        check("wr_mem_din", a_mdin, 32'hDEADBEEF);
        next_cycle();
        a_w0 = 1'b0; a_wd0 = 32'h0;
        #1;
        check("rd_ready0", a_rdy0, 1);
        check("rd_mem_wen", a_mwen, 0);
        check("rd_rvalid0_early", a_rv0, 0);
        next_cycle();
        a_v0 = 1'b0;
        #1;
        check("raw_rvalid0", a_rv0, 1);
        check("raw_rdata0", a_rd0, 32'hDEADBEEF);
        check("raw_rvalid1", a_rv1, 0);
        check("raw_rdata1", a_rd1, 0);
        check("idle_mem_addr", a_maddr, 0);
        check("idle_ready0", a_rdy0, 0);

        // Round-robin from reset, both ports reading continuously
        next_cycle();
        a_reset = 1'b1;
        next_cycle();
        a_reset = 1'b0;
        a_v0 = 1'b1; a_w0 = 1'b0; a_ad0 = 12'h001;
        a_v1 = 1'b1; a_w1 = 1'b0; a_ad1 = 12'h002;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                next_cycle();
                #1;
            end
            check($sformatf("rr_ready0_%0d", i), a_rdy0, (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr_ready1_%0d", i), a_rdy1, (i % 2 == 1) ? 1 : 0);
            check($sformatf("rr_addr_%0d", i), a_maddr, (i % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("rr_cc_%0d", i), a_cc, i);
            if (i > 0) begin
                check($sformatf("rr_rvalid0_%0d", i), a_rv0, (i % 2 == 1) ? 1 : 0);
                check($sformatf("rr_rvalid1_%0d", i), a_rv1, (i % 2 == 0) ? 1 : 0);
                check($sformatf("rr_rdata_%0d", i), (i % 2 == 1) ? a_rd0 : a_rd1,
                      (i % 2 == 1) ? 32'h11 : 32'h22);
            end else begin
                check("rr_rvalid0_0", a_rv0, 0);
                check("rr_rvalid1_0", a_rv1, 0);
            end
        end
        next_cycle();
        a_v0 = 1'b0; a_v1 = 1'b0;
        #1;
        check("rr_tail_rvalid1", a_rv1, 1);
        check("rr_tail_rdata1", a_rd1, 32'h22);
        check("rr_tail_rvalid0", a_rv0, 0);
        check("rr_tail_cc", a_cc, 4);

        // Port 1 write while port 0 idle, then port 0 reads it back
        next_cycle();
        a_v1 = 1'b1; a_w1 = 1'b1; a_ad1 = 12'h0FF; a_wd1 = 32'h12345678;
        #1;
        check("p1wr_ready1", a_rdy1, 1);
        check("p1wr_mem_wen", a_mwen, 1);
        check("p1wr_mem_addr", a_maddr, 32'h0FF);
        check("p1wr_mem_din", a_mdin, 32'h12345678);
        next_cycle();
        a_v1 = 1'b0; a_w1 = 1'b0;
        a_v0 = 1'b1; a_w0 = 1'b0; a_ad0 = 12'h0FF;
        #1;
        check("p0rd_ready0", a_rdy0, 1);
        check("p0rd_mem_wen", a_mwen, 0);
        next_cycle();
        a_v0 = 1'b0;
        #1;
        check("p0rd_rvalid0", a_rv0, 1);
        check("p0rd_rdata0", a_rd0, 32'h12345678);
        check("p0rd_rvalid1", a_rv1, 0);
        check("p0rd_mem_wen_after", a_mwen, 0);

        // Read accepted, then reset on the next cycle: rvalid suppressed
        next_cycle();
        a_v0 = 1'b1; a_w0 = 1'b0; a_ad0 = 12'h001;
        #1;
        check("rdrst_ready0", a_rdy0, 1);
        next_cycle();
        a_reset = 1'b1; a_v1 = 1'b1; a_w1 = 1'b1;
        #1;
        check("rdrst_rvalid0_in_rst", a_rv0, 0);
        check("rdrst_rvalid1_in_rst", a_rv1, 0);
        check("rdrst_ready0_in_rst", a_rdy0, 0);
        check("rdrst_ready1_in_rst", a_rdy1, 0);
        check("rdrst_mem_wen_in_rst", a_mwen, 0);
        next_cycle();
        a_reset = 1'b0; a_v0 = 1'b0; a_v1 = 1'b0; a_w1 = 1'b0;
        #1;
        check("rdrst_rvalid0_after", a_rv0, 0);
        check("rdrst_rvalid1_after", a_rv1, 0);
        check("rdrst_cc", a_cc, 0);

        // Fixed priority and counter saturation on instance B
        next_cycle();
        b_reset = 1'b1;
        next_cycle();
        b_reset = 1'b0; b_v0 = 1'b1; b_v1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            #1;
            check($sformatf("fp_ready0_%0d", i), b_rdy0, 1);
            check($sformatf("fp_ready1_%0d", i), b_rdy1, 0);
            check($sformatf("fp_addr_%0d", i), b_maddr, 32'h005);
        end
        next_cycle();
        #1;
        check("fp_cc4", b_cc, 4);
        for (int i = 5; i < 19; i++) begin
            next_cycle();
            #1;
            if (i == 14) check("sat_cc14", b_cc, 14);
            if (i == 15) check("sat_cc15", b_cc, 15);
        end
        next_cycle();
        b_v0 = 1'b0; b_v1 = 1'b0;
        #1;
        check("sat_cc_hold", b_cc, 15);
        next_cycle();
        #1;
        check("sat_cc_idle", b_cc, 15);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
